// File: rtl/bridge_pkg.sv
// Constants and helpers shared by the UART bridge TX and RX paths.
package bridge_pkg;

  localparam logic [7:0] DEF_PREAMBLE = 8'h4D;
  localparam logic [7:0] CR           = 8'h0D;
  localparam logic [7:0] LF           = 8'h0A;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } tx_state_t;

  // Uppercase ASCII hex digit for one nibble; the RX side decodes the inverse.
  function automatic logic [7:0] ascii_hex(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/bridge_fifo.sv
// Small synchronous FIFO holding pending response words; head is visible combinationally.
module bridge_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a word when a slot frees on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/bridge_tx_stream.sv
// Buffers bus read responses and streams each as an ASCII hex frame to the UART TX core.
module bridge_tx_stream
  import bridge_pkg::*;
#(
  parameter  int          DATA_WIDTH  = 16,
  parameter  int          FIFO_DEPTH  = 4,
  parameter  logic [7:0]  PREAMBLE    = DEF_PREAMBLE,
  parameter  bit          APPEND_CRLF = 1'b1,
  localparam int          CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic [7:0]            data_o,
  output logic                  start_o,
  input  logic                  done_i,
  output logic                  overflow_o,
  input  logic                  overflow_clr_i,
  output logic [CW-1:0]         fifo_count_o
);

  localparam int NDIG = DATA_WIDTH / 4;
  localparam int FLEN = 1 + NDIG + (APPEND_CRLF ? 2 : 0);
  // Sized so that every byte position, including CR/LF, is representable.
  localparam int IW   = $clog2(NDIG + 3);

  tx_state_t             state_reg;
  logic [DATA_WIDTH-1:0] frame_reg;
  logic [IW-1:0]         idx_reg;
  logic                  start_reg;
  logic                  overflow_reg;

  logic [DATA_WIDTH-1:0] head;
  logic                  full;
  logic                  empty;
  logic                  capture;
  logic                  last_byte;
  logic                  pop;
  logic                  drop;
  logic [7:0]            hex_char [NDIG];

  assign capture   = valid_i && !rw_i;
  assign last_byte = (state_reg == ST_SEND) && done_i && (idx_reg == IW'(FLEN - 1));
  assign pop       = !empty && ((state_reg == ST_IDLE) || last_byte);
  assign drop      = capture && full && !pop;

  bridge_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   (data_i),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count_o)
  );

  // Digit gi of the frame carries the nibble gi places below the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_hex
      assign hex_char[gi] = ascii_hex(frame_reg[DATA_WIDTH-1-4*gi -: 4]);
    end
  endgenerate

  always_comb begin
    data_o = 8'h00;
    if (state_reg == ST_SEND) begin
      if (idx_reg == '0)                         data_o = PREAMBLE;
      else if (idx_reg == IW'(NDIG + 1))         data_o = CR;
      else if (idx_reg == IW'(NDIG + 2))         data_o = LF;
      for (int i = 0; i < NDIG; i++) begin
        if (idx_reg == IW'(i + 1)) data_o = hex_char[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      frame_reg <= '0;
      idx_reg   <= '0;
      start_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            frame_reg <= head;
            idx_reg   <= '0;
            start_reg <= 1'b1;
            state_reg <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (done_i) begin
            if (idx_reg == IW'(FLEN - 1)) begin
              idx_reg <= '0;
              // Chain straight into the next frame so start_o never drops.
              if (pop) begin
                frame_reg <= head;
              end else begin
                start_reg <= 1'b0;
                state_reg <= ST_IDLE;
              end
            end else begin
              idx_reg <= idx_reg + IW'(1);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 overflow_reg <= 1'b0;
    else if (drop)           overflow_reg <= 1'b1;
    else if (overflow_clr_i) overflow_reg <= 1'b0;
  end

  assign start_o    = start_reg;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_bridge_tx_stream.sv
// Directed and randomized checks of bridge_tx_stream against a frame-level queue model.
module tb_bridge_tx_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] data_s   [2];
  logic        rw_s     [2];
  logic        valid_s  [2];
  logic        clr_s    [2];
  logic        auto_s   [2];
  int          period_s [2];
  logic        start_w  [2];
  logic [7:0]  data_w   [2];
  logic        ovf_w    [2];
  logic [3:0]  cnt_w    [2];
  logic [7:0]  seen0 [$];
  logic [7:0]  seen1 [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string hs;
    hs = "0123456789ABCDEF";
    return hs[n];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int u, input int budget);
    int n;
    n = 0;
    while ((start_w[u] || cnt_w[u] != 4'd0) && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("u%0d_idle_timeout", u), 64'(n < budget), 64'(1));
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unit
      localparam int DW   = (gi == 0) ? 16 : 32;
      localparam int DEP  = (gi == 0) ? 4 : 2;
      localparam bit CRLF = (gi == 0);
      localparam int NDIG = DW / 4;

      logic                    done;
      logic [7:0]              dout;
      logic                    start;
      logic                    ovf;
      logic [$clog2(DEP):0]    cnt;
      logic [DW-1:0]           mq  [$];
      logic [7:0]              cur [$];
      bit                      m_ovf = 1'b0;

      bridge_tx_stream #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEP),
        .PREAMBLE    (8'h4D),
        .APPEND_CRLF (CRLF)
      ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data_s[gi][DW-1:0]),
        .rw_i           (rw_s[gi]),
        .valid_i        (valid_s[gi]),
        .data_o         (dout),
        .start_o        (start),
        .done_i         (done),
        .overflow_o     (ovf),
        .overflow_clr_i (clr_s[gi]),
        .fifo_count_o   (cnt)
      );

      assign start_w[gi] = start;
      assign data_w[gi]  = dout;
      assign ovf_w[gi]   = ovf;
      assign cnt_w[gi]   = 4'(cnt);

      // Whole frame as the list of bytes still to be sent.
      function automatic void load_frame(input logic [DW-1:0] w);
        cur.delete();
        cur.push_back(8'h4D);
        for (int i = NDIG - 1; i >= 0; i--) cur.push_back(hexc(w[4*i +: 4]));
        if (CRLF) begin
          cur.push_back(8'h0D);
          cur.push_back(8'h0A);
        end
      endfunction

      always @(posedge clk or posedge rst) begin
        bit busy, popw, dropped;
        if (rst) begin
          mq.delete();
          cur.delete();
          m_ovf = 1'b0;
        end else begin
          busy    = (cur.size() != 0);
          popw    = (mq.size() != 0) && (!busy || (done && cur.size() == 1));
          dropped = 1'b0;
          if (busy && done) void'(cur.pop_front());
          if (popw) load_frame(mq.pop_front());
          if (valid_s[gi] && !rw_s[gi]) begin
            if (mq.size() < DEP) mq.push_back(data_s[gi][DW-1:0]);
            else dropped = 1'b1;
          end
          if (dropped)         m_ovf = 1'b1;
          else if (clr_s[gi])  m_ovf = 1'b0;
        end
      end

      always @(negedge clk) begin
        logic [7:0] exp_byte;
        exp_byte = 8'h00;
        if (cur.size() != 0) exp_byte = cur[0];
        chk($sformatf("u%0d_start", gi), 64'(start), 64'(cur.size() != 0));
        chk($sformatf("u%0d_data", gi), 64'(dout), 64'(exp_byte));
        chk($sformatf("u%0d_count", gi), 64'(cnt), 64'(mq.size()));
        chk($sformatf("u%0d_overflow", gi), 64'(ovf), 64'(m_ovf));
      end

      // UART TX stand-in: pulses done every period cycles while a frame is active.
      initial begin
        int cyc;
        done = 1'b0;
        cyc  = 0;
        forever begin
          @(posedge clk);
          #1;
          done = 1'b0;
          if (auto_s[gi] && start && !rst) begin
            cyc++;
            if (cyc >= period_s[gi]) begin
              cyc  = 0;
              done = 1'b1;
              if (gi == 0) seen0.push_back(dout);
              else         seen1.push_back(dout);
            end
          end else begin
            cyc = 0;
          end
        end
      end
    end
  endgenerate

  initial begin
    logic [7:0]  exp1 [7];
    logic [7:0]  exp2 [7];
    logic [7:0]  exp5 [9];
    logic [31:0] w4   [4];
    int          peak;
    int          n;

    for (int u = 0; u < 2; u++) begin
      data_s[u] = '0; rw_s[u] = 1'b0; valid_s[u] = 1'b0;
      clr_s[u] = 1'b0; auto_s[u] = 1'b0; period_s[u] = 1;
    end
    exp1 = '{8'h4D, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    exp2 = '{8'h4D, 8'h30, 8'h39, 8'h41, 8'h46, 8'h0D, 8'h0A};
    exp5 = '{8'h4D, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};

    repeat (3) tick();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_rst_start", u), 64'(start_w[u]), 64'(0));
      chk($sformatf("u%0d_rst_data", u), 64'(data_w[u]), 64'(0));
      chk($sformatf("u%0d_rst_count", u), 64'(cnt_w[u]), 64'(0));
      chk($sformatf("u%0d_rst_ovf", u), 64'(ovf_w[u]), 64'(0));
    end
    rst = 1'b0;
    tick();

    // Single frame, done every 10 cycles.
    auto_s[0] = 1'b1; period_s[0] = 10; seen0.delete();
    valid_s[0] = 1'b1; data_s[0] = 64'h1A2F;
    tick();
    valid_s[0] = 1'b0;
    chk("t1_k_start", 64'(start_w[0]), 64'(0));
    chk("t1_k_count", 64'(cnt_w[0]), 64'(1));
    tick();
    chk("t1_k1_start", 64'(start_w[0]), 64'(1));
    chk("t1_k1_data", 64'(data_w[0]), 64'h4D);
    chk("t1_k1_count", 64'(cnt_w[0]), 64'(0));
    wait_idle(0, 200);
    chk("t1_len", 64'(seen0.size()), 64'(7));
    for (int i = 0; i < 7; i++)
      if (i < seen0.size()) chk($sformatf("t1_byte%0d", i), 64'(seen0[i]), 64'(exp1[i]));

    // Nibble boundaries, then a write that must be ignored.
    period_s[0] = 3; seen0.delete();
    valid_s[0] = 1'b1; data_s[0] = 64'h09AF;
    tick();
    rw_s[0] = 1'b1; data_s[0] = 64'hFFFF;
    tick();
    valid_s[0] = 1'b0; rw_s[0] = 1'b0;
    chk("t2_write_count", 64'(cnt_w[0]), 64'(0));
    wait_idle(0, 200);
    chk("t2_len", 64'(seen0.size()), 64'(7));
    for (int i = 0; i < 7; i++)
      if (i < seen0.size()) chk($sformatf("t2_byte%0d", i), 64'(seen0[i]), 64'(exp2[i]));

    // Back-to-back frames with done on consecutive cycles.
    period_s[0] = 1; seen0.delete();
    for (int i = 1; i <= 3; i++) begin
      valid_s[0] = 1'b1; data_s[0] = 64'(i);
      tick();
    end
    valid_s[0] = 1'b0;
    peak = 0; n = 0;
    while ((start_w[0] || cnt_w[0] != 4'd0) && n < 400) begin
      if (int'(cnt_w[0]) > peak) peak = int'(cnt_w[0]);
      tick();
      n++;
    end
    chk("t3_timeout", 64'(n < 400), 64'(1));
    chk("t3_peak", 64'(peak), 64'(2));
    chk("t3_len", 64'(seen0.size()), 64'(21));
    if (seen0.size() == 21) begin
      chk("t3_f1_last_digit", 64'(seen0[4]), 64'h31);
      chk("t3_f2_preamble", 64'(seen0[7]), 64'h4D);
      chk("t3_f2_last_digit", 64'(seen0[11]), 64'h32);
      chk("t3_f3_last_digit", 64'(seen0[18]), 64'h33);
    end

    // Overflow on the depth-2 unit; no done pulses while filling.
    auto_s[1] = 1'b0; seen1.delete();
    for (int i = 0; i < 4; i++) w4[i] = $urandom;
    w4[3] = w4[2] ^ 32'h0000_000F;
    for (int i = 0; i < 4; i++) begin
      valid_s[1] = 1'b1; data_s[1] = {32'h0, w4[i]};
      tick();
      if (i == 2) chk("t4_no_ovf_yet", 64'(ovf_w[1]), 64'(0));
    end
    valid_s[1] = 1'b0;
    chk("t4_ovf_set", 64'(ovf_w[1]), 64'(1));
    chk("t4_count_full", 64'(cnt_w[1]), 64'(2));
    clr_s[1] = 1'b1;
    tick();
    clr_s[1] = 1'b0;
    chk("t4_ovf_clr", 64'(ovf_w[1]), 64'(0));
    valid_s[1] = 1'b1; clr_s[1] = 1'b1; data_s[1] = 64'h1234_5678;
    tick();
    valid_s[1] = 1'b0;
    chk("t4_set_wins", 64'(ovf_w[1]), 64'(1));
    tick();
    clr_s[1] = 1'b0;
    chk("t4_ovf_clr2", 64'(ovf_w[1]), 64'(0));
    auto_s[1] = 1'b1; period_s[1] = 2;
    wait_idle(1, 500);
    chk("t4_len", 64'(seen1.size()), 64'(27));
    if (seen1.size() == 27) begin
      chk("t4_f2_preamble", 64'(seen1[9]), 64'h4D);
      chk("t4_f3_preamble", 64'(seen1[18]), 64'h4D);
      chk("t4_f3_is_word2", 64'(seen1[26]), 64'(hexc(w4[2][3:0])));
    end

    // Wide word, no CR/LF.
    period_s[1] = 2; seen1.delete();
    valid_s[1] = 1'b1; data_s[1] = 64'hDEAD_BEEF;
    tick();
    valid_s[1] = 1'b0;
    wait_idle(1, 200);
    chk("t5_len", 64'(seen1.size()), 64'(9));
    for (int i = 0; i < 9; i++)
      if (i < seen1.size()) chk($sformatf("t5_byte%0d", i), 64'(seen1[i]), 64'(exp5[i]));

    // Asynchronous reset in the middle of a frame with another word queued.
    period_s[0] = 4; seen0.delete();
    valid_s[0] = 1'b1; data_s[0] = 64'h1234;
    tick();
    data_s[0] = 64'h5678;
    tick();
    valid_s[0] = 1'b0;
    n = 0;
    while (seen0.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    chk("t6_timeout", 64'(n < 200), 64'(1));
    tick();
    chk("t6_pre_start", 64'(start_w[0]), 64'(1));
    chk("t6_pre_count", 64'(cnt_w[0]), 64'(1));
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_start", 64'(start_w[0]), 64'(0));
    chk("t6_rst_count", 64'(cnt_w[0]), 64'(0));
    chk("t6_rst_data", 64'(data_w[0]), 64'(0));
    #2;
    rst = 1'b0;
    tick();
    seen0.delete();
    valid_s[0] = 1'b1; data_s[0] = 64'h5A5A;
    tick();
    valid_s[0] = 1'b0;
    wait_idle(0, 200);
    chk("t6_len", 64'(seen0.size()), 64'(7));
    if (seen0.size() == 7) begin
      chk("t6_preamble", 64'(seen0[0]), 64'h4D);
      chk("t6_digit0", 64'(seen0[1]), 64'h35);
    end

    // Random traffic on both units, checked every cycle by the model.
    for (int c = 0; c < 600; c++) begin
      for (int u = 0; u < 2; u++) begin
        if (c % 40 == 0) begin
          auto_s[u]   = ($urandom_range(0, 3) != 0);
          period_s[u] = $urandom_range(1, 6);
        end
        valid_s[u] = ($urandom_range(0, 2) == 0);
        rw_s[u]    = ($urandom_range(0, 3) == 0);
        data_s[u]  = {$urandom, $urandom};
        clr_s[u]   = ($urandom_range(0, 15) == 0);
      end
      tick();
    end
    for (int u = 0; u < 2; u++) begin
      valid_s[u] = 1'b0; clr_s[u] = 1'b0; auto_s[u] = 1'b1;
    end
    wait_idle(0, 2000);
    wait_idle(1, 2000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bridge_tx_stream.md
# bridge_tx_stream

Parametrised UART bridge response transmitter. It captures read-response words from the internal bus into a small FIFO and serialises each one as an ASCII frame: preamble, hex digits MSB-first, and optional CR/LF. Frames go out one byte at a time to the UART transmitter. It sits between the bus and the UART TX core, and adds configurable word width, back-to-back buffering and overflow reporting.

## Interface

**Parameters**
- `DATA_WIDTH`, 16: response word width; multiple of 4, range 4..64.
- `FIFO_DEPTH`, 4: pending-response slots; power of 2, ≥2.
- `PREAMBLE`, 8'h4D: first byte of every frame.
- `APPEND_CRLF`, 1: 1 appends 8'h0D, 8'h0A; 0 omits them.

**Ports**
- `clk` in 1: sole clock.
- `rst` in 1: reset; asynchronous, active-high.
- `data_i` in DATA_WIDTH: bus read-response data.
- `rw_i` in 1: 0 = read response (captured), 1 = write (ignored).
- `valid_i` in 1: bus word valid.
- `data_o` out 8: byte presented to the UART TX core.
- `start_o` out 1: high while a frame is being sent (level).
- `done_i` in 1: one-cycle pulse from the UART TX core when the current byte has finished.
- `overflow_o` out 1: sticky; a response was dropped because the FIFO was full.
- `overflow_clr_i` in 1: synchronous clear of `overflow_o`.
- `fifo_count_o` out clog2(FIFO_DEPTH)+1: words waiting in the FIFO, excluding the frame in flight.

## Operation

**Capture**
- Capture condition: `valid_i && !rw_i` sampled at a rising edge.
- Push succeeds if the FIFO is not full, or if a pop happens in the same cycle.
- Otherwise the word is dropped and `overflow_o` sets on that edge.
- If `overflow_clr_i` and a new overflow occur on the same edge, set wins.

**Frame format**
- Frame = PREAMBLE, then NDIG = DATA_WIDTH/4 hex characters (most significant nibble first), then CR, LF when APPEND_CRLF.
- FLEN = 1 + NDIG + 2·APPEND_CRLF.
- Nibble encoding: 0–9 → 8'h30–8'h39; 10–15 → 8'h41–8'h46 (uppercase).

**State machine**
- Two states: IDLE and SEND.
- IDLE:
  - `start_o`=0, `data_o`=8'h00.
  - If the FIFO is non-empty: pop the head into the frame buffer, set byte index=0, go to SEND.
  - `done_i` is ignored.
- SEND:
  - `start_o`=1; `data_o` is a combinational function of byte index and frame buffer.
  - Each `done_i` increments the index.
  - On `done_i` at index FLEN−1:
    - FIFO non-empty: pop the next word, index=0, stay in SEND. `start_o` does not drop (back-to-back).
    - FIFO empty: go to IDLE.
- Pop and push on the same edge are legal. `fifo_count_o` is unchanged in that case.
- `done_i` is assumed to be at most one pulse per byte. Consecutive-cycle pulses each advance the index.

**Reset**
- `rst` asserted at any time, including mid-frame, takes effect immediately.
- Resets: state=IDLE, index=0, FIFO emptied, `overflow_o`=0, `start_o`=0, `data_o`=8'h00, `fifo_count_o`=0.
- The frame in flight is abandoned.

## Timing

- Capture at edge k into an empty FIFO while IDLE: pop at edge k+1; `start_o`=1 and `data_o`=PREAMBLE from edge k+1.
- Byte advance: `data_o` shows the next byte from the edge that sampled `done_i`.
- Last `done_i` with FIFO empty: `start_o`=0 from that edge.
- Back-to-back frames: no idle cycle between frames.
- `overflow_o` asserts on the dropping edge; clears on the edge sampling `overflow_clr_i`.
- `fifo_count_o` is registered and updates on push/pop edges.

## Structure

**Shared package `bridge_pkg`**
- PREAMBLE, CR (8'h0D) and LF (8'h0A) constants.
- The `ascii_hex` nibble-to-ASCII function, shared with the RX side's inverse.

**Sub-module `bridge_fifo`**
- Parametrised synchronous FIFO.
- Parameters: WIDTH, DEPTH.
- Ports: push, pop, full, empty, count.
- Asynchronous clear on `rst`.

The frame FSM, index counter and byte mux stay in `bridge_tx_stream`.

## Test plan

1. **Single frame.** DATA_WIDTH=16: one read of 16'h1A2F, `done_i` pulsed every 10 cycles → bytes 4D 31 41 32 46 0D 0A in order. `start_o` high from edge k+1 until the 7th `done_i`.
2. **Nibble boundary / writes ignored.** Read 16'h09AF → 4D 30 39 41 46 0D 0A. A write (`rw_i`=1) of 16'hFFFF on the next cycle produces no frame and leaves `fifo_count_o`=0.
3. **Back-to-back.** Reads 16'h0001, 16'h0002, 16'h0003 on consecutive cycles, depth 4 → 21 bytes, frames in order. `start_o` never drops; peak `fifo_count_o`=2.
4. **Overflow.** FIFO_DEPTH=2: reads on edges 0–3 with no `done_i` → words 0–2 kept, word 3 dropped, `overflow_o`=1 at edge 3. Exactly 3 frames are sent. `overflow_clr_i` then clears the flag.
5. **Wide, no CR/LF.** DATA_WIDTH=32, APPEND_CRLF=0: read 32'hDEADBEEF → 4D 44 45 41 44 42 45 45 46 (9 bytes), then IDLE.
6. **Reset mid-frame.** `rst` pulsed after the 3rd `done_i` → `start_o`=0 immediately, `fifo_count_o`=0. The next read produces a full frame starting with 4D.
